window_feeder: RTL and testbench

- Initiator side of the 3x3 window-buffer load/shift interface.
- Reads pixels from frame memory, drives them into the window buffer one byte at a time, and issues the shift commands.
- Walks the image in a serpentine scan and presents each completed window to the Sobel core with a valid/ack handshake.
- Sits between the frame-memory read port and the window buffer / Sobel compute stage.

---
 rtl/window_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_window_feeder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_feeder.sv
// window_feeder: drives the 3x3 window buffer from frame memory.
// The image is walked in a serpentine order starting at the bottom-left
// window. Each window is built with one shift command followed by 9 (fresh
// load) or 3 (incremental move) pixel transfers, and is then offered to the
// Sobel core until it is acknowledged.
module window_feeder #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       mem_ren,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [7:0]                 mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       start_shift,
    output logic [1:0]                 shift_direc,
    input  logic                       shift_done,
    output logic                       start_read,
    output logic [7:0]                 data_r,
    input  logic                       read_done,
    output logic                       win_valid,
    input  logic                       win_ack,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [1:0] DIR_LOAD  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, SHIFT, SHIFT_ACK, MEM_REQ, MEM_WAIT,
        PUSH, PUSH_ACK, PRESENT, NEXT, DONE
    } state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            right_q, right_d;     // horizontal travel direction
    logic [1:0]      direc_q, direc_d;
    logic [3:0]      cnt_q, cnt_d;         // pixel index within window
    logic            ack_seen;             // ack caught in the command cycle
    logic [3:0]      last_idx;
    logic            row_end;

    // Address of pixel k of the current window for a given shift direction.
    // Loads run bottom row first; column moves bring in one new column
    // bottom-up; a move up brings in the new top row left to right.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [1:0]    d,
        input logic [RW-1:0] ar,
        input logic [CW-1:0] ac,
        input logic [3:0]    k
    );
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [3:0]        kr;
        logic [3:0]        kc;
        kr  = k / 4'd3;
        kc  = k % 4'd3;
        row = ADDR_W'(ar) + ADDR_W'(2);
        col = ADDR_W'(ac);
        case (d)
            DIR_LOAD: begin
                row = row - ADDR_W'(kr);
                col = col + ADDR_W'(kc);
            end
            DIR_LEFT: begin
                row = row - ADDR_W'(k);
                col = col + ADDR_W'(2);
            end
            DIR_RIGHT: begin
                row = row - ADDR_W'(k);
            end
            default: begin
                row = ADDR_W'(ar);
                col = col + ADDR_W'(k);
            end
        endcase
        return row * ADDR_W'(IMG_W) + col;
    endfunction

    assign last_idx = (direc_q == DIR_LOAD) ? 4'd8 : 4'd2;
    assign row_end  = right_q ? (col_q == CW'(IMG_W - 3)) : (col_q == '0);

    // Command pulses and status are pure state decodes.
    assign mem_ren     = (state == MEM_REQ);
    assign start_shift = (state == SHIFT);
    assign start_read  = (state == PUSH);
    assign win_valid   = (state == PRESENT);
    assign frame_done  = (state == DONE);
    assign busy        = (state != IDLE) && (state != DONE);
    assign shift_direc = direc_q;
    assign win_row     = row_q;
    assign win_col     = col_q;

    // Next-state, anchor and direction selection.
    always_comb begin
        state_d = state;
        row_d   = row_q;
        col_d   = col_q;
        right_d = right_q;
        direc_d = direc_q;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    row_d   = RW'(IMG_H - 3);
                    col_d   = '0;
                    right_d = 1'b1;
                    direc_d = DIR_LOAD;
                    cnt_d   = '0;
                end
            end
            SHIFT:     state_d = SHIFT_ACK;
            SHIFT_ACK: begin
                if (shift_done || ack_seen) begin
                    state_d = MEM_REQ;
                    cnt_d   = '0;
                end
            end
            MEM_REQ:   state_d = MEM_WAIT;
            MEM_WAIT:  if (mem_rvalid) state_d = PUSH;
            PUSH:      state_d = PUSH_ACK;
            PUSH_ACK: begin
                if (read_done || ack_seen) begin
                    if (cnt_q == last_idx) begin
                        state_d = PRESENT;
                    end else begin
                        state_d = MEM_REQ;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            PRESENT:   if (win_ack) state_d = NEXT;
            NEXT: begin
                if (row_end) begin
                    if (row_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        row_d   = row_q - RW'(1);
                        right_d = ~right_q;
                        direc_d = DIR_DOWN;
                    end
                end else if (right_q) begin
                    state_d = SHIFT;
                    col_d   = col_q + CW'(1);
                    direc_d = DIR_LEFT;
                end else begin
                    state_d = SHIFT;
                    col_d   = col_q - CW'(1);
                    direc_d = DIR_RIGHT;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State, anchor and pixel counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            right_q <= 1'b0;
            direc_q <= DIR_LOAD;
            cnt_q   <= '0;
        end else begin
            state   <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            right_q <= right_d;
            direc_q <= direc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Remember an acknowledge that arrives in the same cycle as its command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_seen <= 1'b0;
        end else if (state == SHIFT) begin
            ack_seen <= shift_done;
        end else if (state == PUSH) begin
            ack_seen <= read_done;
        end
    end

    // Address is set up on entry to MEM_REQ and held through the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (state_d == MEM_REQ) begin
            mem_addr <= pix_addr(direc_q, row_q, col_q, cnt_d);
        end
    end

    // Capture returning pixel; held stable for the buffer write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else if (state == MEM_WAIT && mem_rvalid) begin
            data_r <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
`timescale 1ns/1ps
// Scoreboard bench for window_feeder: a 5x4 instance exercised with random
// pixels and latencies, plus a 3x3 instance for the single-window case.
module tb_window_feeder;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- 5x4 DUT ----------------
    logic          start;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_rvalid;
    logic          start_shift;
    logic [1:0]    shift_direc;
    logic          shift_done;
    logic          start_read;
    logic [7:0]    data_r;
    logic          read_done;
    logic          win_valid;
    logic          win_ack;
    logic [1:0]    win_row;
    logic [2:0]    win_col;
    logic          busy;
    logic          frame_done;

    logic rv_resp = 1'b0, rv_spur = 1'b0;
    logic sd_resp = 1'b0, rd_resp = 1'b0;
    logic ack_resp = 1'b0, ack_spur = 1'b0;
    int   mem_lat = 1, sd_dly = 0, rd_dly = 0, ack_dly = 0;

    assign mem_rvalid = rv_resp | rv_spur;
    assign shift_done = (sd_dly == 0) ? start_shift : sd_resp;
    assign read_done  = (rd_dly == 0) ? start_read : rd_resp;
    assign win_ack    = ack_resp | ack_spur;

    window_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .start_shift(start_shift), .shift_direc(shift_direc),
        .shift_done(shift_done),
        .start_read(start_read), .data_r(data_r), .read_done(read_done),
        .win_valid(win_valid), .win_ack(win_ack),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done)
    );

    // ---------------- 3x3 DUT ----------------
    logic          s_start;
    logic          s_mem_ren;
    logic [AW-1:0] s_mem_addr;
    logic [7:0]    s_rd = 8'h00;
    logic          s_rv = 1'b0;
    logic          s_ss, s_sr, s_wv, s_busy, s_fd;
    logic [1:0]    s_dir;
    logic [7:0]    s_data;
    logic [1:0]    s_row, s_col;

    window_feeder #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) u_small (
        .clk(clk), .rst(rst), .start(s_start),
        .mem_ren(s_mem_ren), .mem_addr(s_mem_addr), .mem_rdata(s_rd),
        .mem_rvalid(s_rv),
        .start_shift(s_ss), .shift_direc(s_dir), .shift_done(s_ss),
        .start_read(s_sr), .data_r(s_data), .read_done(s_sr),
        .win_valid(s_wv), .win_ack(s_wv),
        .win_row(s_row), .win_col(s_col),
        .busy(s_busy), .frame_done(s_fd)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0, n_bad = 0;
    int frames_seen = 0;
    logic [7:0]  mem_a [W*H];
    logic [1:0]  dir_q[$];
    int          addr_q[$];
    logic [7:0]  data_q[$];
    logic [15:0] win_q[$];
    int          s_addr_q[$];
    int          s_win_cnt = 0, s_frames = 0, s_shifts = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] s_mem(input int a);
        return 8'((a * 29 + 11) & 255);
    endfunction

    task automatic push_pix(input int r, input int c);
        addr_q.push_back(r * W + c);
        data_q.push_back(mem_a[r * W + c]);
    endtask

    // Reference: enumerate the serpentine list of anchors; the shift kind is
    // the step between consecutive anchors, the pixels are the entering ones.
    task automatic build_frame();
        int pr, pc, c;
        bit first, right;
        logic [1:0] d;
        for (int i = 0; i < W * H; i++) mem_a[i] = 8'($urandom);
        dir_q.delete(); addr_q.delete(); data_q.delete(); win_q.delete();
        first = 1; right = 1; pr = 0; pc = 0;
        for (int r = H - 3; r >= 0; r--) begin
            for (int i = 0; i < W - 2; i++) begin
                c = right ? i : (W - 3 - i);
                if (first)        d = 2'b00;
                else if (r != pr) d = 2'b11;
                else if (c > pc)  d = 2'b01;
                else              d = 2'b10;
                dir_q.push_back(d);
                case (d)
                    2'b00: for (int rr = 2; rr >= 0; rr--)
                               for (int cc = 0; cc < 3; cc++) push_pix(r + rr, c + cc);
                    2'b01: for (int rr = 2; rr >= 0; rr--) push_pix(r + rr, c + 2);
                    2'b10: for (int rr = 2; rr >= 0; rr--) push_pix(r + rr, c);
                    default: for (int cc = 0; cc < 3; cc++) push_pix(r, c + cc);
                endcase
                win_q.push_back({8'(r), 8'(c)});
                pr = r; pc = c; first = 0;
            end
            right = !right;
        end
    endtask

    // Memory model: answers each read after mem_lat cycles.
    initial begin : mem_resp
        int a;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (mem_ren && !rst) begin
                a = int'(mem_addr) % (W * H);
                repeat (mem_lat) @(posedge clk);
                #1; rv_resp = 1'b1; mem_rdata = mem_a[a];
                @(posedge clk); #1; rv_resp = 1'b0; mem_rdata = 8'($urandom);
            end
        end
    end

    initial begin : shift_resp
        forever begin
            @(posedge clk); #1;
            if (start_shift && sd_dly > 0) begin
                repeat (sd_dly) @(posedge clk);
                #1; sd_resp = 1'b1;
                @(posedge clk); #1; sd_resp = 1'b0;
            end
        end
    end

    initial begin : read_resp
        forever begin
            @(posedge clk); #1;
            if (start_read && rd_dly > 0) begin
                repeat (rd_dly) @(posedge clk);
                #1; rd_resp = 1'b1;
                @(posedge clk); #1; rd_resp = 1'b0;
            end
        end
    end

    initial begin : ack_resp_p
        forever begin
            @(posedge clk); #1;
            if (win_valid) begin
                repeat (ack_dly) @(posedge clk);
                #1; ack_resp = 1'b1;
                @(posedge clk); #1; ack_resp = 1'b0;
            end
        end
    end

    // Monitor for the 5x4 DUT, sampled on the falling edge.
    initial begin : mon
        logic ss_prev, sr_prev, wv_prev;
        logic [15:0] hold;
        ss_prev = 0; sr_prev = 0; wv_prev = 0; hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ss_prev = 0; sr_prev = 0; wv_prev = 0;
            end else begin
                if (start_shift || start_read)
                    chk("cmd_exclusive", longint'(start_shift & start_read), 0);
                if (start_shift) begin
                    chk("shift_width", longint'(ss_prev), 0);
                    chk("shift_expected", longint'(dir_q.size() > 0), 1);
                    if (dir_q.size() > 0) chk("shift_direc", shift_direc, dir_q.pop_front());
                end
                if (mem_ren) begin
                    chk("read_expected", longint'(addr_q.size() > 0), 1);
                    if (addr_q.size() > 0) chk("mem_addr", mem_addr, addr_q.pop_front());
                end
                if (start_read) begin
                    chk("push_width", longint'(sr_prev), 0);
                    chk("push_expected", longint'(data_q.size() > 0), 1);
                    if (data_q.size() > 0) chk("data_r", data_r, data_q.pop_front());
                end
                if (win_valid) begin
                    if (!wv_prev) begin
                        chk("win_expected", longint'(win_q.size() > 0), 1);
                        if (win_q.size() > 0) hold = win_q.pop_front();
                        chk("win_row", win_row, hold[15:8]);
                        chk("win_col", win_col, hold[7:0]);
                    end else begin
                        chk("win_stable", {win_row, win_col}, {hold[9:8], hold[2:0]});
                    end
                end
                if (frame_done) frames_seen++;
                ss_prev = start_shift; sr_prev = start_read; wv_prev = win_valid;
            end
        end
    end

    // 3x3 memory: one cycle after the request.
    initial begin : s_mem_resp
        logic pend;
        logic [7:0] pd;
        pend = 0; pd = 0;
        forever begin
            @(posedge clk); #1;
            s_rv = pend; s_rd = pend ? pd : 8'($urandom);
            pend = s_mem_ren;
            pd   = s_mem(int'(s_mem_addr));
        end
    end

    initial begin : s_mon
        logic wv_prev;
        int a;
        wv_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_ss) begin
                    s_shifts++;
                    chk("s_direc", s_dir, 0);
                end
                if (s_mem_ren) begin
                    chk("s_read_expected", longint'(s_addr_q.size() > 0), 1);
                    if (s_addr_q.size() > 0) begin
                        a = s_addr_q.pop_front();
                        chk("s_mem_addr", s_mem_addr, a);
                    end
                end
                if (s_sr) chk("s_data_r", s_data, s_mem(int'(s_mem_addr)));
                if (s_wv && !wv_prev) begin
                    s_win_cnt++;
                    chk("s_win_pos", {s_row, s_col}, 0);
                end
                if (s_fd) s_frames++;
                wv_prev = s_wv;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk("frame_done_seen", longint'(frame_done), 1);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_ctrl"}, {mem_ren, start_shift, start_read, win_valid, busy, frame_done}, 0);
        chk({name, "_addr"}, mem_addr, 0);
        chk({name, "_data"}, data_r, 0);
        chk({name, "_pos"}, {win_row, win_col, shift_direc}, 0);
    endtask

    task automatic run_frame(input int lat, input int sd, input int rd, input int ack,
                             input bit poke);
        int f0;
        mem_lat = lat; sd_dly = sd; rd_dly = rd; ack_dly = ack;
        build_frame();
        f0 = frames_seen;
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (40) @(posedge clk);
            #1; start = 1;
            @(posedge clk); #1; start = 0;
        end
        wait_done(20000);
        @(posedge clk); #1;
        chk("frame_done_pulse", frame_done, 0);
        chk("busy_after_done", busy, 0);
        chk("frame_count", frames_seen - f0, 1);
        chk("left_dir", dir_q.size(), 0);
        chk("left_addr", addr_q.size(), 0);
        chk("left_win", win_q.size(), 0);
    endtask

    initial begin : main
        int n, k;
        rst = 1; start = 0; s_start = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 0;
        @(posedge clk); #1;

        // Combinational acks, 1-cycle memory.
        run_frame(1, 0, 0, 0, 0);
        // Slow acks, variable memory latency, start pulsed mid-scan.
        run_frame(int'($urandom_range(1, 3)), 3, 3, 10, 1);

        // Spurious inputs while idle.
        rv_spur = 1; ack_spur = 1;
        @(posedge clk); #1; rv_spur = 0; ack_spur = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_spurious", {mem_ren, start_shift, start_read, win_valid, busy}, 0);

        // Reset while waiting for memory.
        mem_lat = 3; sd_dly = 0; rd_dly = 0; ack_dly = 0;
        build_frame();
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
        n = 0; k = 0;
        while (k < 4 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (mem_ren) k++;
        end
        chk("reached_4th_read", k, 4);
        @(posedge clk); #1;
        rst = 1;
        dir_q.delete(); addr_q.delete(); data_q.delete(); win_q.delete();
        @(posedge clk); #1;
        check_idle("in_reset");
        rst = 0;
        repeat (6) @(posedge clk);
        #1;
        check_idle("after_reset");
        run_frame(int'($urandom_range(1, 2)), 1, 2, 3, 0);

        // Minimal 3x3 image: one window from a full load.
        for (int rr = 2; rr >= 0; rr--)
            for (int cc = 0; cc < 3; cc++) s_addr_q.push_back(rr * 3 + cc);
        @(posedge clk); #1; s_start = 1;
        @(posedge clk); #1; s_start = 0;
        n = 0;
        while (!s_fd && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("s_frame_done_seen", s_fd, 1);
        @(posedge clk); #1;
        chk("s_busy_after", s_busy, 0);
        chk("s_reads_left", s_addr_q.size(), 0);
        chk("s_windows", s_win_cnt, 1);
        chk("s_shifts", s_shifts, 1);
        chk("s_frames", s_frames, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
